memory_stage: RTL
=================

Name: memory_stage

Overview:
- Y86-64 SEQ memory stage. Sits directly downstream of the execute stage and consumes its valE plus the decoded operands.
- Performs at most one 64-bit data-memory read or write per instruction over a req/ack bus with variable latency.
- Produces valM and the updated status for the writeback and PC-update stages.
- Valid/ready handshake on both the upstream and downstream sides. Multi-cycle FSM with an ack-timeout watchdog.

Parameters:
- ADDR_LIMIT, 8192: size of data memory in bytes. A legal 8-byte access needs addr + 8 <= ADDR_LIMIT.
- TIMEOUT, 16: maximum cycles dmem_req may stay high without dmem_ack before the access is aborted.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute results valid
- in_ready  out  1  stage can accept; equals (state==IDLE)
- icode  in  4  instruction code
- valE  in  64  execute result / effective address
- valA  in  64  register A operand
- valP  in  64  fall-through PC (return address for call)
- stat_in  in  3  status so far: 1=AOK, 2=HLT, 3=ADR, 4=INS
- out_valid  out  1  results valid
- out_ready  in  1  downstream accepts
- icode_out  out  4  registered icode
- valE_out  out  64  registered valE
- valM  out  64  read data; 0 when there is no read
- stat_out  out  3  final status
- dmem_req  out  1  memory request
- dmem_we  out  1  1=write, 0=read
- dmem_addr  out  64  byte address
- dmem_wdata  out  64  write data
- dmem_rdata  in  64  read data, valid when dmem_ack=1
- dmem_ack  in  1  single-cycle completion strobe

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0; valM=0; valE_out=0; icode_out=0; stat_out=1.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0; timeout counter=0.
  - All of these take effect immediately, without waiting for a clock edge.
- Access decode, evaluated at accept:
  - 4 rmmovq: write, addr=valE, data=valA
  - 5 mrmovq: read, addr=valE
  - 8 call: write, addr=valE, data=valP
  - 9 ret: read, addr=valA
  - A pushq: write, addr=valE, data=valA
  - B popq: read, addr=valA
  - Any other icode: no access.
- Address check: bad if the 65-bit unsigned sum addr+8 > ADDR_LIMIT. The wide compare makes wrap-around addresses (e.g. 0xFFFF_FFFF_FFFF_FFFC) bad.
- FSM states: IDLE, REQ, DONE.
  - IDLE: in_ready=1. On in_valid, capture icode, valE and stat_in.
    - If stat_in != 1, or there is no access, or the address is bad: go to DONE next cycle. valM=0. stat_out is stat_in if stat_in != 1, otherwise 3 for a bad address, otherwise 1. No dmem_req is issued.
    - Otherwise go to REQ with dmem_req=1 and dmem_we/addr/wdata registered.
  - REQ: hold dmem_req and all dmem_* outputs stable.
    - On dmem_ack=1: drop dmem_req at the next edge, latch valM=dmem_rdata for reads (0 for writes), stat_out=1, go to DONE.
    - On the TIMEOUT-th REQ cycle with no ack: drop dmem_req, valM=0, stat_out=3, go to DONE.
  - DONE: out_valid=1 and outputs held stable. On out_ready=1, go to IDLE next cycle and clear out_valid.
- dmem_ack is ignored outside REQ.
- Minimum latency: accept at edge 0, dmem_req visible in cycle 1. An ack in cycle 1 gives out_valid in cycle 2. A no-access instruction gives out_valid in cycle 1.
- Throughput: at most one instruction per 2 cycles. in_ready=0 in REQ and DONE.
- Reset mid-REQ: dmem_req drops asynchronously and any in-flight transaction is abandoned. The memory side must tolerate the dropped request.

Test Plan:
- mrmovq, valE=0x100, ack in the 3rd REQ cycle with rdata=0x1122334455667788 -> dmem_req=1/we=0/addr=0x100 for cycles 1-3; out_valid in cycle 4 with valM=0x1122334455667788, stat_out=1.
- pushq, valE=0x1F8, valA=0xDEAD, ack in the same cycle -> we=1, addr=0x1F8, wdata=0xDEAD; out_valid in cycle 2 with valM=0, stat_out=1.
- rmmovq, valE=0x1FF9 (ADDR_LIMIT-7) -> no dmem_req; out_valid in cycle 1 with stat_out=3. valE=0x1FF8 -> request issued.
- popq, valA=0x40, ack never arrives -> dmem_req high for exactly 16 cycles, then low; out_valid with valM=0, stat_out=3. A late ack is ignored.
- OPq (icode 6), valE=0x7, with out_ready held low for 5 cycles -> no dmem_req; out_valid, valE_out=0x7 and stat_out=1 held stable with in_ready=0 throughout; in_ready=1 the cycle after out_ready rises. Also with stat_in=2 (HLT) on an mrmovq -> no request, stat_out=2.
- Assert rst_n=0 during a REQ cycle -> dmem_req and out_valid go to 0 immediately; after release, in_ready=1 and stat_out=1.

Source files
------------

// File: rtl/memory_stage.sv
// Y86-64 SEQ memory stage: one optional 64-bit data access per instruction
// over a req/ack bus, with an ack-timeout watchdog and valid/ready handshakes.
module memory_stage #(
    parameter int unsigned ADDR_LIMIT = 8192,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    input  logic [2:0]  stat_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  icode_out,
    output logic [63:0] valE_out,
    output logic [63:0] valM,
    output logic [2:0]  stat_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_ack
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [2:0]  STAT_AOK = 3'd1;
    localparam logic [2:0]  STAT_ADR = 3'd3;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_d, dmem_req_d, dmem_we_d;
    logic [3:0]         icode_out_d;
    logic [63:0]        valE_out_d, valM_d, dmem_addr_d, dmem_wdata_d;
    logic [2:0]         stat_out_d;

    logic               acc, acc_we, addr_bad;
    logic [63:0]        acc_addr, acc_wdata;

    // Access decode from the incoming instruction
    always_comb begin
        acc       = 1'b0;
        acc_we    = 1'b0;
        acc_addr  = valE;
        acc_wdata = valA;
        case (icode)
            4'h4: begin acc = 1'b1; acc_we = 1'b1; end
            4'h5: begin acc = 1'b1; end
            4'h8: begin acc = 1'b1; acc_we = 1'b1; acc_wdata = valP; end
            4'h9: begin acc = 1'b1; acc_addr = valA; end
            4'hA: begin acc = 1'b1; acc_we = 1'b1; end
            4'hB: begin acc = 1'b1; acc_addr = valA; end
            default: ;
        endcase
    end

    // 65-bit compare so that addresses near 2^64 wrap into the bad range
    assign addr_bad = ({1'b0, acc_addr} + 65'd8) > 65'(ADDR_LIMIT);

    assign in_ready = (state_q == IDLE);

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid;
        icode_out_d  = icode_out;
        valE_out_d   = valE_out;
        valM_d       = valM;
        stat_out_d   = stat_out;
        dmem_req_d   = dmem_req;
        dmem_we_d    = dmem_we;
        dmem_addr_d  = dmem_addr;
        dmem_wdata_d = dmem_wdata;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    icode_out_d = icode;
                    valE_out_d  = valE;
                    valM_d      = 64'd0;
                    cnt_d       = '0;
                    if (stat_in != STAT_AOK || !acc || addr_bad) begin
                        stat_out_d  = (stat_in != STAT_AOK) ? stat_in : (acc && addr_bad) ? STAT_ADR : STAT_AOK;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        stat_out_d   = STAT_AOK;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = acc_we;
                        dmem_addr_d  = acc_addr;
                        dmem_wdata_d = acc_wdata;
                        state_d      = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_ack) begin
                    dmem_req_d  = 1'b0;
                    valM_d      = dmem_we ? 64'd0 : dmem_rdata;
                    stat_out_d  = STAT_AOK;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    dmem_req_d  = 1'b0;
                    valM_d      = 64'd0;
                    stat_out_d  = STAT_ADR;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            out_valid  <= 1'b0;
            icode_out  <= 4'd0;
            valE_out   <= 64'd0;
            valM       <= 64'd0;
            stat_out   <= STAT_AOK;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 64'd0;
            dmem_wdata <= 64'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_valid  <= out_valid_d;
            icode_out  <= icode_out_d;
            valE_out   <= valE_out_d;
            valM       <= valM_d;
            stat_out   <= stat_out_d;
            dmem_req   <= dmem_req_d;
            dmem_we    <= dmem_we_d;
            dmem_addr  <= dmem_addr_d;
            dmem_wdata <= dmem_wdata_d;
        end
    end

endmodule
